// File: rtl/inv_interp_if.sv
// Handshake bundle for inv_interp_seq: operand side (in_*) and result side (out_*),
// each with its own valid/ready pair.
interface inv_interp_if #(
    parameter int IW_M = 4,
    parameter int QW_M = 12,
    parameter int IW_B = 8,
    parameter int QW_B = 10,
    parameter int IW_Y = 8,
    parameter int QW_Y = 14,
    parameter int IW_X = 6,
    parameter int QW_X = 10
);
    logic                          in_valid;
    logic                          in_ready;
    logic signed [IW_M+QW_M-1:0]   m;
    logic signed [IW_B+QW_B-1:0]   b;
    logic signed [IW_Y+QW_Y-1:0]   y;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [IW_X+QW_X-1:0]   x;
    logic                          sat;
    logic                          div0;

    modport master (
        output in_valid, m, b, y, out_ready,
        input  in_ready, out_valid, x, sat, div0
    );

    modport slave (
        input  in_valid, m, b, y, out_ready,
        output in_ready, out_valid, x, sat, div0
    );
endinterface

// File: rtl/inv_interp_seq.sv
// Sequential inverse interpolator: x = (y - b) / m in signed fixed point, one
// quotient bit per cycle through a restoring magnitude divider; latency NW+1.
module inv_interp_seq #(
    parameter int IW_M = 4,
    parameter int QW_M = 12,
    parameter int IW_B = 8,
    parameter int QW_B = 10,
    parameter int IW_Y = 8,
    parameter int QW_Y = 14,
    parameter int IW_X = 6,
    parameter int QW_X = 10
) (
    input  logic        clk,
    input  logic        rst,
    inv_interp_if.slave bus
);
    localparam int IW_D = ((IW_Y > IW_B) ? IW_Y : IW_B) + 1;
    localparam int QW_D = (QW_Y > QW_B) ? QW_Y : QW_B;
    localparam int DW   = IW_D + QW_D;
    localparam int S    = QW_X + QW_M - QW_D;
    localparam int NW   = DW + S;
    localparam int MW   = IW_M + QW_M;
    localparam int W    = IW_X + QW_X;
    localparam int CW   = (NW > 1) ? $clog2(NW) : 1;

    localparam logic signed [W-1:0] X_MAX     = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] X_MIN     = {1'b1, {(W-1){1'b0}}};
    localparam logic [NW-1:0]       Q_POS_LIM = NW'(X_MAX);
    localparam logic [NW-1:0]       Q_NEG_LIM = Q_POS_LIM + NW'(1);

    if (S < 0) begin : g_fmt_chk
        $fatal(1, "inv_interp_seq: QW_X + QW_M must not be smaller than max(QW_Y, QW_B)");
    end

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    // Returns {sat, div0, x}. A negative quotient of exactly 2^(W-1) is representable.
    function automatic logic [W+1:0] saturate(input logic [NW-1:0] q,
                                              input logic          neg,
                                              input logic          mzero,
                                              input logic          dneg);
        logic signed [W-1:0] xv;
        logic                sv;
        logic                dv;
        xv = q[W-1:0];
        sv = 1'b0;
        dv = 1'b0;
        if (mzero) begin
            sv = 1'b1;
            dv = 1'b1;
            xv = dneg ? X_MIN : X_MAX;
        end else if (neg) begin
            if (q > Q_NEG_LIM) begin
                sv = 1'b1;
                xv = X_MIN;
            end else begin
                xv = -q[W-1:0];
            end
        end else if (q > Q_POS_LIM) begin
            sv = 1'b1;
            xv = X_MAX;
        end
        return {sv, dv, xv};
    endfunction

    state_t state, state_n;
    logic   in_ready_c, accept, load_out, hs_out;

    logic signed [DW-1:0] y_al, b_al, diff;
    logic signed [DW:0]   diff_w;
    logic [DW:0]          dmag;
    logic signed [MW:0]   m_w;
    logic [MW:0]          mmag;
    logic [NW-1:0]        num_n;

    logic [MW-1:0]        dvs_p0;
    logic                 neg_p0, dneg_p0, mz_p0;
    logic [NW-1:0]        num_p1, q_p1;
    logic [MW-1:0]        rem_p1;
    logic [CW-1:0]        cnt_p1;
    logic                 vld_p2;
    logic signed [W-1:0]  x_p2;
    logic                 sat_p2, div0_p2;

    logic [MW:0]          sh;
    logic [MW+1:0]        trial;
    logic                 qbit;
    logic [MW-1:0]        rem_n;

    // Operand conditioning: align binary points, then take magnitudes one bit wider
    assign y_al   = DW'(bus.y) <<< (QW_D - QW_Y);
    assign b_al   = DW'(bus.b) <<< (QW_D - QW_B);
    assign diff   = y_al - b_al;
    assign diff_w = (DW+1)'(diff);
    assign dmag   = diff_w[DW] ? (DW+1)'(-diff_w) : (DW+1)'(diff_w);
    assign num_n  = NW'(dmag) << S;
    assign m_w    = (MW+1)'(bus.m);
    assign mmag   = m_w[MW] ? (MW+1)'(-m_w) : (MW+1)'(m_w);

    // Restoring step: shift in the next numerator bit, keep the difference if it fits
    assign sh    = {rem_p1, num_p1[NW-1]};
    assign trial = {1'b0, sh} - {2'b00, dvs_p0};
    assign qbit  = ~trial[MW+1];
    assign rem_n = qbit ? MW'(trial) : sh[MW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        in_ready_c = 1'b0;
        accept     = 1'b0;
        load_out   = 1'b0;
        hs_out     = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_n = DIV;
                end
            end
            DIV: begin
                if (cnt_p1 == CW'(NW - 1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (!vld_p2) begin
                    load_out = 1'b1;
                end else if (bus.out_ready) begin
                    hs_out  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // p0/p1: operand capture and iteration state
    always_ff @(posedge clk) begin
        if (accept) begin
            num_p1  <= num_n;
            dvs_p0  <= MW'(mmag);
            neg_p0  <= diff[DW-1] ^ bus.m[MW-1];
            dneg_p0 <= diff[DW-1];
            mz_p0   <= (bus.m == '0);
            rem_p1  <= '0;
            q_p1    <= '0;
        end else if (state == DIV) begin
            num_p1 <= num_p1 << 1;
            rem_p1 <= rem_n;
            q_p1   <= {q_p1[NW-2:0], qbit};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p1 <= '0;
        end else if (accept) begin
            cnt_p1 <= '0;
        end else if (state == DIV) begin
            cnt_p1 <= cnt_p1 + CW'(1);
        end
    end

    // p2: registered, held result
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            x_p2    <= '0;
            sat_p2  <= 1'b0;
            div0_p2 <= 1'b0;
        end else if (load_out) begin
            vld_p2                    <= 1'b1;
            {sat_p2, div0_p2, x_p2}   <= saturate(q_p1, neg_p0, mz_p0, dneg_p0);
        end else if (hs_out) begin
            vld_p2 <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = vld_p2;
    assign bus.x         = x_p2;
    assign bus.sat       = sat_p2;
    assign bus.div0      = div0_p2;
endmodule
